// File: rtl/lc3_mem_pkg.sv
// Shared types and helpers for the LC-3 SRAM responder.
package lc3_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR1     = 2'd2,
        WR_HOLD = 2'd3
    } resp_state_t;

    typedef struct packed {
        logic rd;
        logic wr;
    } strobe_t;

    // Turns the active-low bus strobes into read/write requests; WE low
    // always means a write, even if OE is also low.
    function automatic strobe_t decode_strobes(input logic ce_n,
                                               input logic oe_n,
                                               input logic we_n);
        strobe_t s;
        s.rd = ~ce_n & ~oe_n & we_n;
        s.wr = ~ce_n & ~we_n;
        return s;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word array with per-byte write enables and an asynchronous
// read port. Contents are deliberately not reset.
module sram_array
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WORD_W-1:0] Wr_data,
    input  logic              We_hi,
    input  logic              We_lo,
    output logic [WORD_W-1:0] Rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-lane writes.
    always_ff @(posedge Clk) begin
        if (We_hi) mem[Addr][15:8] <= Wr_data[15:8];
        if (We_lo) mem[Addr][7:0]  <= Wr_data[7:0];
    end

    assign Rd_data = mem[Addr];

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the LC-3 SRAM control bus.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no access in progress
//   RD      | OE-low read in progress, data reloaded each edge
//   WR1     | first WE-low cycle seen, commit pending
//   WR_HOLD | write committed, waiting for WE to rise
module sram_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [DATA_W-1:0] Init_data,
    output logic              Busy,
    output logic [15:0]       Rd_count,
    output logic [15:0]       Wr_count
);

    resp_state_t       state, next_state;
    strobe_t           strb;
    logic              commit;
    logic              rd_entry;
    logic              rd_take;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic              arr_we_hi;
    logic              arr_we_lo;

    assign strb = decode_strobes(Mem_CE, Mem_OE, Mem_WE);

    // Preload owns the array port whenever it is active; CPU strobes are ignored.
    assign commit    = (state == WR1) & strb.wr & ~Init_we;
    assign rd_take   = strb.rd & ~Init_we;
    assign rd_entry  = (next_state == RD) & (state != RD) & ~Init_we;
    assign arr_addr  = Init_we ? Init_addr : ADDR;
    assign arr_wdata = Init_we ? Init_data : Data_from_CPU;
    assign arr_we_hi = Init_we | (commit & ~Mem_UB);
    assign arr_we_lo = Init_we | (commit & ~Mem_LB);
    assign Busy      = (state == WR1) | (state == WR_HOLD);

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .Clk     (Clk),
        .Addr    (arr_addr),
        .Wr_data (arr_wdata),
        .We_hi   (arr_we_hi),
        .We_lo   (arr_we_lo),
        .Rd_data (arr_rdata)
    );

    // State register; preload forces the FSM back to IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)        state <= IDLE;
        else if (Init_we) state <= IDLE;
        else              state <= next_state;
    end

    // Next-state decode; a write request always wins over a read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (strb.rd)      next_state = RD;
                else if (strb.wr) next_state = WR1;
            end
            RD: begin
                if (strb.rd)      next_state = RD;
                else if (strb.wr) next_state = WR1;
                else              next_state = IDLE;
            end
            WR1: begin
                if (strb.wr) next_state = WR_HOLD;
                else         next_state = IDLE;
            end
            WR_HOLD: begin
                if (strb.wr) next_state = WR_HOLD;
                else         next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered read data with disabled lanes forced to zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data_to_CPU <= '0;
        end else if (rd_take) begin
            Data_to_CPU <= {Mem_UB ? 8'h00 : arr_rdata[15:8],
                            Mem_LB ? 8'h00 : arr_rdata[7:0]};
        end
    end

    // Saturating access counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Rd_count <= '0;
            Wr_count <= '0;
        end else begin
            if (rd_entry && (Rd_count != 16'hFFFF)) Rd_count <= Rd_count + 16'd1;
            if (commit   && (Wr_count != 16'hFFFF)) Wr_count <= Wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: a run-length based reference
// model checked every cycle, plus directed literal expectations.
module tb_sram_responder;

    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] ADDR = '0;
    logic [15:0]   Data_from_CPU = '0;
    logic [15:0]   Data_to_CPU;
    logic          Mem_CE = 1'b1, Mem_UB = 1'b0, Mem_LB = 1'b0;
    logic          Mem_OE = 1'b1, Mem_WE = 1'b1;
    logic          Init_we = 1'b0;
    logic [AW-1:0] Init_addr = '0;
    logic [15:0]   Init_data = '0;
    logic          Busy;
    logic [15:0]   Rd_count, Wr_count;

    int n_checks = 0;
    int n_errors = 0;

    sram_responder #(.ADDR_W(AW), .DATA_W(16)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .Data_from_CPU (Data_from_CPU),
        .Data_to_CPU   (Data_to_CPU),
        .Mem_CE        (Mem_CE),
        .Mem_UB        (Mem_UB),
        .Mem_LB        (Mem_LB),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .Init_we       (Init_we),
        .Init_addr     (Init_addr),
        .Init_data     (Init_data),
        .Busy          (Busy),
        .Rd_count      (Rd_count),
        .Wr_count      (Wr_count)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    localparam int K_NONE = 0, K_READ = 1, K_WRITE = 2;

    logic [15:0] m_mem [0:(1<<AW)-1];
    logic [15:0] m_dout = '0;
    logic [15:0] m_rdc = '0;
    logic [15:0] m_wrc = '0;
    int          run = 0;      // consecutive accepted WE-low edges
    int          last = K_NONE; // what the previous edge did

    function automatic logic [15:0] lanes(input logic ub, input logic lb, input logic [15:0] w);
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    always @(posedge Clk or posedge Reset) begin
        logic rd_now, wr_now;
        if (Reset) begin
            m_dout = '0; m_rdc = '0; m_wrc = '0; run = 0; last = K_NONE;
        end else if (Init_we) begin
            m_mem[Init_addr] = Init_data;
            run = 0; last = K_NONE;
        end else begin
            rd_now = !Mem_CE && !Mem_OE && Mem_WE;
            wr_now = !Mem_CE && !Mem_WE;
            if (rd_now) m_dout = lanes(Mem_UB, Mem_LB, m_mem[ADDR]);
            if (wr_now) begin
                if (run < 3) run++;
                if (run == 2) begin
                    if (!Mem_UB) m_mem[ADDR][15:8] = Data_from_CPU[15:8];
                    if (!Mem_LB) m_mem[ADDR][7:0]  = Data_from_CPU[7:0];
                    if (m_wrc != 16'hFFFF) m_wrc++;
                end
            end else begin
                run = 0;
            end
            if (wr_now) last = K_WRITE;
            else if (rd_now && last != K_WRITE) begin
                if (last == K_NONE && m_rdc != 16'hFFFF) m_rdc++;
                last = K_READ;
            end else last = K_NONE;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge Clk) begin
        chk("data_to_cpu", Data_to_CPU, m_dout);
        chk("busy", {15'd0, Busy}, {15'd0, (last == K_WRITE)});
        chk("rd_count", Rd_count, m_rdc);
        chk("wr_count", Wr_count, m_wrc);
    end

    // ---------------- stimulus helpers (called just after a negedge) ----------------
    task automatic cyc(input logic ce, input logic oe, input logic we, input logic ub,
                       input logic lb, input logic [AW-1:0] a, input logic [15:0] d);
        Init_we = 1'b0;
        Mem_CE = ce; Mem_OE = oe; Mem_WE = we; Mem_UB = ub; Mem_LB = lb;
        ADDR = a; Data_from_CPU = d;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        Init_we = 1'b1; Init_addr = a; Init_data = d;
        @(posedge Clk); @(negedge Clk);
        Init_we = 1'b0;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Init_we = 1'b0;
        #2 Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int busy_n;
        @(negedge Clk);
        #1;
        chk("reset_data", Data_to_CPU, 16'h0000);
        chk("reset_busy", {15'd0, Busy}, 16'h0000);
        chk("reset_rdc", Rd_count, 16'h0000);
        chk("reset_wrc", Wr_count, 16'h0000);
        @(negedge Clk);
        #2 Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 128; i++) preload(AW'(i), 16'($urandom));

        // Plain read of a preloaded word.
        do_reset();
        preload(10'h012, 16'hBEEF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h012, '0);
        chk("t1_data_first_edge", Data_to_CPU, 16'hBEEF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h012, '0);
        chk("t1_rd_count", Rd_count, 16'd1);
        idle();

        // Two-cycle write, Busy for exactly two cycles.
        do_reset();
        busy_n = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h020, 16'h1234); busy_n += int'(Busy);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h020, 16'h1234); busy_n += int'(Busy);
        idle(); busy_n += int'(Busy);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h020, '0);
        chk("t2_readback", Data_to_CPU, 16'h1234);
        chk("t2_wr_count", Wr_count, 16'd1);
        chk("t2_busy_cycles", 16'(busy_n), 16'd2);
        idle();

        // Lower-lane-only write, then lane-masked reads.
        preload(10'h030, 16'hAAAA);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h030, 16'h5555);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h030, 16'h5555);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h030, '0);
        chk("t3_byte_write", Data_to_CPU, 16'hAA55);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h030, '0);
        chk("t3_lb_masked", Data_to_CPU, 16'hAA00);
        idle();

        // One-cycle WE pulse must not commit.
        preload(10'h040, 16'h0F0F);
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h040, 16'hFFFF);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h040, '0);
        chk("t4_short_pulse", Data_to_CPU, 16'h0F0F);
        chk("t4_wr_count", Wr_count, 16'd0);
        idle();

        // Long WE pulse commits exactly once, with the second cycle's data.
        do_reset();
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h050, 16'(i));
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h050, '0);
        chk("t5_long_pulse", Data_to_CPU, 16'h0002);
        chk("t5_wr_count", Wr_count, 16'd1);
        idle();

        // Reset during WR1 aborts the write.
        preload(10'h060, 16'h1111);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h060, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h060, 16'h2222);
        #2 Reset = 1'b1;
        #1;
        chk("t6_rst_busy", {15'd0, Busy}, 16'h0000);
        chk("t6_rst_data", Data_to_CPU, 16'h0000);
        chk("t6_rst_rdc", Rd_count, 16'h0000);
        chk("t6_rst_wrc", Wr_count, 16'h0000);
        @(posedge Clk); @(negedge Clk);
        Mem_CE = 1'b1; Mem_WE = 1'b1;
        #2 Reset = 1'b0;
        @(negedge Clk);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h060, '0);
        chk("t6_no_commit", Data_to_CPU, 16'h1111);
        // OE and WE both low: a write, read data untouched.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h060, 16'h3333);
        chk("t6_oe_we_hold", Data_to_CPU, 16'h1111);
        chk("t6_oe_we_busy", {15'd0, Busy}, 16'h0001);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h060, 16'h3333);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h060, '0);
        chk("t6_oe_we_written", Data_to_CPU, 16'h3333);
        chk("t6_wr_count", Wr_count, 16'd1);
        idle();

        // Randomized traffic, including preloads and resets mid-access.
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [AW-1:0] a;
            r = int'($urandom_range(99));
            a = ($urandom_range(3) == 0) ? AW'($urandom_range(127)) : AW'($urandom_range(7));
            if (r < 1) do_reset();
            else if (r < 7) preload(a, 16'($urandom));
            else cyc(($urandom_range(9) == 0), 1'($urandom), ($urandom_range(2) == 0),
                     ($urandom_range(4) == 0), ($urandom_range(4) == 0), a, 16'($urandom));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the LC-3 datapath's SRAM control bus. It answers the controller's active-low Mem_CE/Mem_UB/Mem_LB/Mem_OE/Mem_WE strobes using an on-chip word array. Reads are 2-cycle OE-low accesses and writes are 2-cycle WE-low accesses. It replaces the external SRAM in simulation and on-chip builds, and provides a preload port so a program image can be loaded before Run.

## Interface
Parameters:
- ADDR_W, default 10: word-address width; array depth is 2**ADDR_W words.
- DATA_W, default 16: word width. Must be 16, two byte lanes.

Ports:
- Clk  in  1  system clock. Every register samples on the rising edge.
- Reset  in  1  asynchronous, active-high.
- ADDR  in  ADDR_W  word address, driven from MAR.
- Data_from_CPU  in  16  write data, driven from MDR.
- Data_to_CPU  out  16  registered read data, loaded into MDR.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  in  1 each  active-low chip enable, upper-byte lane, lower-byte lane, output enable, write enable.
- Init_we  in  1  preload write strobe, active-high.
- Init_addr  in  ADDR_W  preload address.
- Init_data  in  16  preload data, always a full word.
- Busy  out  1  high while a write is in progress (states WR1, WR_HOLD).
- Rd_count, Wr_count  out  16 each  saturating access counters.

## Operation
- Decoded strobes:
  - rd = ~Mem_CE & ~Mem_OE & Mem_WE
  - wr = ~Mem_CE & ~Mem_WE
  - When OE and WE are both low, the access is a write. WE wins.
- FSM states (lc3_mem_pkg::resp_state_t): IDLE, RD, WR1, WR_HOLD.
  - IDLE: on rd, go to RD; on wr, go to WR1; otherwise stay.
  - RD: on rd, stay; on wr, go to WR1; otherwise go to IDLE.
  - WR1: on wr, commit the write and go to WR_HOLD; otherwise abort (no array write) and go to IDLE.
  - WR_HOLD: on wr, stay with no further writes; otherwise go to IDLE.
  - Result: exactly one commit per WE-low pulse of 2 or more cycles.
- Read:
  - On every edge where rd is true, Data_to_CPU <= {UB ? 8'h00 : mem[ADDR][15:8], LB ? 8'h00 : mem[ADDR][7:0]}.
  - A disabled lane reads as zero.
  - Otherwise Data_to_CPU holds its value.
- Write commit:
  - The commit uses ADDR, Data_from_CPU, and the lane enables sampled on the commit edge.
  - Only enabled lanes are written.
  - A write with both lanes disabled commits nothing but still counts.
- Preload:
  - Init_we has priority over everything.
  - When Init_we=1: mem[Init_addr] <= Init_data, the FSM is forced to IDLE, and CPU strobes are ignored that cycle.
  - Preload writes are not counted.
- Counters:
  - Rd_count increments on each IDLE->RD or WR_HOLD->... no: on each entry into RD from any other state.
  - Wr_count increments on each commit.
  - Both saturate at 16'hFFFF.
- ADDR is exactly ADDR_W bits wide, so there is no out-of-range case; the controller truncates upper MAR bits.

## Timing
- Reset values:
  - State = IDLE
  - Data_to_CPU = 16'h0000
  - Busy = 0
  - Rd_count = Wr_count = 0
  - Array contents are not reset.
- Read latency: with rd first true at edge k, Data_to_CPU is valid after edge k. The controller's second OE cycle therefore loads MDR at edge k+1 with correct data.
- Write latency: the array is updated at edge k+1, where k is the first WE-low edge. A read of the same address returns the new data from edge k+2 onward.
- Busy is combinational from the state register: high in WR1 and WR_HOLD.
- Reset asserted mid-write (in WR1) means no commit occurs.
- Reset during WR_HOLD leaves the committed data intact.
- A write interrupted by Init_we is aborted. The preload write still occurs.

## Structure
- Package lc3_mem_pkg holds:
  - resp_state_t
  - localparam WORD_W = 16
  - the strobe-decode helper function
- Sub-module sram_array:
  - single-port, 2**ADDR_W × 16
  - per-byte write enables
  - asynchronous read port
  - the responder registers the read output
- The FSM, counters, and the preload mux live in sram_responder.

## Test plan
- Preload mem[0x012]=16'hBEEF; drive CE=0, OE=0, UB=LB=0, ADDR=0x012 for 2 cycles -> Data_to_CPU=16'hBEEF after the first edge; Rd_count=1.
- CE=0, WE=0, UB=LB=0, ADDR=0x020, Data_from_CPU=16'h1234 for 2 cycles, then WE=1; read 0x020 -> 16'h1234; Wr_count=1; Busy high for exactly 2 cycles.
- Preload 0x030=16'hAAAA; write 16'h5555 with UB=1, LB=0 -> read returns 16'hAA55. Read with LB=1 -> 16'hAA00.
- WE low for 1 cycle only, ADDR=0x040 preloaded 16'h0F0F, data 16'hFFFF -> mem unchanged (16'h0F0F); Wr_count=0.
- WE low for 5 cycles with data changing each cycle (16'h0001..16'h0005) -> mem holds 16'h0002; Wr_count=1.
- Assert Reset during WR1 -> no commit; all outputs at reset values. OE and WE both low -> treated as a write and Data_to_CPU unchanged.
